// File: rtl/io_port_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : io_port_bus_ctrl
//  Purpose  : Bus-side controller for the GPIO port block. It accepts
//             four-phase REQ/ACK transactions from the CPU and decodes a
//             4-entry register window at BASE_ADDR. It drives the single-cycle
//             load strobes for the port direction register (PDR_EN) and the
//             port data register (PORT_EN). It opens the PORT_RD window on the
//             read tri-state buffer and returns the captured pin value on
//             BUS_RDATA.
//
//  Register window (offset from BASE_ADDR):
//             +0 DIR  (R/W, bit0)   +1 DATA (R/W)
//             +2 PIN  (RO, through the PORT_RD window; writes have no effect)
//             +3 IRQ clear (only with IO_PORT_CHANGE_IRQ_EN, else unmapped)
//
//  Ports    : CLK, RST (sync, active high)
//             BUS_REQ/BUS_WE/BUS_ADDR/BUS_WDATA  -> CPU request side
//             BUS_RDATA/BUS_ACK/BUS_ERR          <- CPU response side
//             PDR_EN/PDR_DATA                    -> direction register load
//             PORT_EN/PORT_DATA                  -> data register load
//             PORT_RD/PORT_READ_DATA             <-> pin read path
//             IRQ (optional)                     -> sticky pin-change flag
//
//  Config   : `define IO_PORT_CHANGE_IRQ_EN adds the IRQ output, the
//             last-pin tracker and the IRQ-clear register at BASE_ADDR+3.
//             BASE_ADDR must be 4-aligned; READ_WAIT must lie in 0..7.
//
//  Revision : 1.0  initial release
// ============================================================================
module io_port_bus_ctrl #(
    parameter int         DATA_W    = 8,
    parameter logic [7:0] BASE_ADDR = 8'hF0,
    parameter int         READ_WAIT = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              BUS_REQ,
    input  logic              BUS_WE,
    input  logic [7:0]        BUS_ADDR,
    input  logic [DATA_W-1:0] BUS_WDATA,
    output logic [DATA_W-1:0] BUS_RDATA,
    output logic              BUS_ACK,
    output logic              BUS_ERR,
    output logic              PDR_EN,
    output logic              PDR_DATA,
    output logic              PORT_EN,
    output logic [DATA_W-1:0] PORT_DATA,
    output logic              PORT_RD,
    input  logic [DATA_W-1:0] PORT_READ_DATA
`ifdef IO_PORT_CHANGE_IRQ_EN
    ,
    output logic              IRQ
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WRITE   = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_ACK     = 2'd3
    } state_t;

    localparam logic [1:0] c_OFF_DIR   = 2'd0;
    localparam logic [1:0] c_OFF_DATA  = 2'd1;
    localparam logic [1:0] c_OFF_PIN   = 2'd2;
    localparam logic [1:0] c_OFF_IRQ   = 2'd3;
    localparam logic [2:0] c_WAIT_LOAD = 3'(READ_WAIT);
`ifdef IO_PORT_CHANGE_IRQ_EN
    localparam logic       c_IRQ_EN    = 1'b1;
`else
    localparam logic       c_IRQ_EN    = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t            r_state,     w_state_nxt;
    logic [2:0]        r_wait_cnt,  w_wait_cnt_nxt;
    logic              r_err_pend,  w_err_pend_nxt;
    logic              r_dir,       w_dir_nxt;
    logic [DATA_W-1:0] r_data_sh,   w_data_sh_nxt;
    logic [DATA_W-1:0] r_rdata,     w_rdata_nxt;
    logic              r_ack,       w_ack_nxt;
    logic              r_err,       w_err_nxt;
    logic              r_pdr_en,    w_pdr_en_nxt;
    logic              r_pdr_data,  w_pdr_data_nxt;
    logic              r_port_en,   w_port_en_nxt;
    logic [DATA_W-1:0] r_port_data, w_port_data_nxt;
    logic              r_port_rd,   w_port_rd_nxt;
`ifdef IO_PORT_CHANGE_IRQ_EN
    logic              r_irq,       w_irq_nxt;
    logic [DATA_W-1:0] r_last_pin,  w_last_pin_nxt;
    logic              w_irq_set;
    logic              w_irq_clr;
`endif

    // Address decode works on the live bus; it only matters on the
    // request edge, which is the only time IDLE looks at it.
    logic       w_in_window;
    logic [1:0] w_off;
    logic       w_mapped;

    assign w_in_window = (BUS_ADDR[7:2] == BASE_ADDR[7:2]);
    assign w_off       = BUS_ADDR[1:0];
    assign w_mapped    = w_in_window && ((w_off != c_OFF_IRQ) || c_IRQ_EN);

    // ------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_wait_cnt_nxt  = r_wait_cnt;
        w_err_pend_nxt  = r_err_pend;
        w_dir_nxt       = r_dir;
        w_data_sh_nxt   = r_data_sh;
        w_rdata_nxt     = r_rdata;
        w_ack_nxt       = r_ack;
        w_err_nxt       = r_err;
        w_pdr_en_nxt    = 1'b0;           // strobes are single-cycle by default
        w_pdr_data_nxt  = r_pdr_data;
        w_port_en_nxt   = 1'b0;
        w_port_data_nxt = r_port_data;
        w_port_rd_nxt   = r_port_rd;
`ifdef IO_PORT_CHANGE_IRQ_EN
        w_irq_set       = 1'b0;
        w_irq_clr       = 1'b0;
        w_last_pin_nxt  = r_last_pin;
`endif

        case (r_state)
            ST_IDLE: begin
                if (BUS_REQ) begin
                    w_err_pend_nxt = 1'b0;
                    if (!w_mapped) begin
                        // Unmapped: no strobes, read data untouched.
                        w_err_pend_nxt = 1'b1;
                        w_state_nxt    = ST_ACK;
                    end else if (BUS_WE) begin
                        // Strobes rise on the request edge so they are
                        // high exactly during the WRITE state.
                        w_state_nxt = ST_WRITE;
                        case (w_off)
                            c_OFF_DIR: begin
                                w_pdr_en_nxt   = 1'b1;
                                w_pdr_data_nxt = BUS_WDATA[0];
                                w_dir_nxt      = BUS_WDATA[0];
                            end
                            c_OFF_DATA: begin
                                w_port_en_nxt   = 1'b1;
                                w_port_data_nxt = BUS_WDATA;
                                w_data_sh_nxt   = BUS_WDATA;
                            end
`ifdef IO_PORT_CHANGE_IRQ_EN
                            c_OFF_IRQ: w_irq_clr = 1'b1;
`endif
                            default: ;    // PIN is read-only
                        endcase
                    end else if (w_off == c_OFF_PIN) begin
                        w_state_nxt    = ST_RD_WAIT;
                        w_port_rd_nxt  = 1'b1;
                        w_wait_cnt_nxt = c_WAIT_LOAD;
                    end else begin
                        w_state_nxt = ST_ACK;
                        case (w_off)
                            c_OFF_DIR:  w_rdata_nxt = {{(DATA_W-1){1'b0}}, r_dir};
                            c_OFF_DATA: w_rdata_nxt = r_data_sh;
`ifdef IO_PORT_CHANGE_IRQ_EN
                            c_OFF_IRQ:  w_rdata_nxt = {{(DATA_W-1){1'b0}}, r_irq};
`endif
                            default: ;
                        endcase
                    end
                end
            end

            ST_WRITE: begin
                w_state_nxt = ST_ACK;
            end

            ST_RD_WAIT: begin
                if (r_wait_cnt == 3'd0) begin
                    // Final edge of the window: capture, close, acknowledge.
                    w_rdata_nxt   = PORT_READ_DATA;
                    w_port_rd_nxt = 1'b0;
                    w_ack_nxt     = 1'b1;
                    w_state_nxt   = ST_ACK;
`ifdef IO_PORT_CHANGE_IRQ_EN
                    w_irq_set      = (PORT_READ_DATA != r_last_pin);
                    w_last_pin_nxt = PORT_READ_DATA;
`endif
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt - 3'd1;
                end
            end

            ST_ACK: begin
                if (!r_ack) begin
                    // First ACK cycle after a write, shadow read or
                    // unmapped access; pin reads arrive with ACK already set.
                    // The ack is raised even if REQ already dropped, so an
                    // abandoned request still sees a one-cycle pulse.
                    w_ack_nxt = 1'b1;
                    w_err_nxt = r_err_pend;
                end else if (!BUS_REQ) begin
                    w_ack_nxt   = 1'b0;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

`ifdef IO_PORT_CHANGE_IRQ_EN
        // Sticky flag; a set on the same edge as a clear takes priority.
        w_irq_nxt = r_irq;
        if (w_irq_clr) begin
            w_irq_nxt = 1'b0;
        end
        if (w_irq_set) begin
            w_irq_nxt = 1'b1;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_wait_cnt  <= 3'd0;
            r_err_pend  <= 1'b0;
            r_dir       <= 1'b0;
            r_data_sh   <= '0;
            r_rdata     <= '0;
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
            r_pdr_en    <= 1'b0;
            r_pdr_data  <= 1'b0;
            r_port_en   <= 1'b0;
            r_port_data <= '0;
            r_port_rd   <= 1'b0;
`ifdef IO_PORT_CHANGE_IRQ_EN
            r_irq       <= 1'b0;
            r_last_pin  <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
            r_err_pend  <= w_err_pend_nxt;
            r_dir       <= w_dir_nxt;
            r_data_sh   <= w_data_sh_nxt;
            r_rdata     <= w_rdata_nxt;
            r_ack       <= w_ack_nxt;
            r_err       <= w_err_nxt;
            r_pdr_en    <= w_pdr_en_nxt;
            r_pdr_data  <= w_pdr_data_nxt;
            r_port_en   <= w_port_en_nxt;
            r_port_data <= w_port_data_nxt;
            r_port_rd   <= w_port_rd_nxt;
`ifdef IO_PORT_CHANGE_IRQ_EN
            r_irq       <= w_irq_nxt;
            r_last_pin  <= w_last_pin_nxt;
`endif
        end
    end

    assign BUS_RDATA = r_rdata;
    assign BUS_ACK   = r_ack;
    assign BUS_ERR   = r_err;
    assign PDR_EN    = r_pdr_en;
    assign PDR_DATA  = r_pdr_data;
    assign PORT_EN   = r_port_en;
    assign PORT_DATA = r_port_data;
    assign PORT_RD   = r_port_rd;
`ifdef IO_PORT_CHANGE_IRQ_EN
    assign IRQ       = r_irq;
`endif

endmodule
`default_nettype wire

// File: tb/tb_io_port_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_io_port_bus_ctrl
//  Purpose  : Self-checking bench for io_port_bus_ctrl. Expected responses
//             are pushed to a scoreboard queue as each request is issued and
//             popped when the acknowledge arrives.
//  Revision : 1.0  initial release
// ============================================================================
module tb_io_port_bus_ctrl;

    localparam int DW = 8;
    localparam int RW = 1;

    logic          clk;
    logic          rst;
    logic          bus_req;
    logic          bus_we;
    logic [7:0]    bus_addr;
    logic [DW-1:0] bus_wdata;
    logic [DW-1:0] bus_rdata;
    logic          bus_ack;
    logic          bus_err;
    logic          pdr_en;
    logic          pdr_data;
    logic          port_en;
    logic [DW-1:0] port_data;
    logic          port_rd;
    logic [DW-1:0] port_read_data;
`ifdef IO_PORT_CHANGE_IRQ_EN
    logic          irq;
`endif

    int checks = 0;
    int errors = 0;

    // Reference state of the register block as the CPU should see it.
    logic [DW-1:0] m_rdata;
    logic [DW-1:0] m_data;
    logic          m_dir;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        int            lat;
        int            n_pdr;
        logic          pdr_val;
        int            n_port;
        logic [DW-1:0] port_val;
        int            n_rd;
    } exp_t;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        int            lat;
        int            n_pdr;
        logic          pdr_val;
        int            n_port;
        logic [DW-1:0] port_val;
        int            n_rd;
        bit            timeout;
        bit            excl_bad;
        logic          rd_at_ack;
        logic          ack_after;
    } obs_t;

    typedef struct {
        logic          we;
        logic [7:0]    addr;
        logic [DW-1:0] wdata;
    } stim_t;

    exp_t exp_q[$];

    io_port_bus_ctrl #(
        .DATA_W    (DW),
        .BASE_ADDR (8'hF0),
        .READ_WAIT (RW)
    ) dut (
        .CLK            (clk),
        .RST            (rst),
        .BUS_REQ        (bus_req),
        .BUS_WE         (bus_we),
        .BUS_ADDR       (bus_addr),
        .BUS_WDATA      (bus_wdata),
        .BUS_RDATA      (bus_rdata),
        .BUS_ACK        (bus_ack),
        .BUS_ERR        (bus_err),
        .PDR_EN         (pdr_en),
        .PDR_DATA       (pdr_data),
        .PORT_EN        (port_en),
        .PORT_DATA      (port_data),
        .PORT_RD        (port_rd),
        .PORT_READ_DATA (port_read_data)
`ifdef IO_PORT_CHANGE_IRQ_EN
        ,
        .IRQ            (irq)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drives one request and records what the DUT did, sampling 1 unit after
    // each rising edge. Address/control/data are scrambled right after the
    // request edge. With early_drop, REQ falls before the ack arrives.
    task automatic bus_txn(input logic we, input logic [7:0] addr,
                           input logic [DW-1:0] wdata, input bit early_drop,
                           output obs_t o);
        o.rdata = '0; o.err = 1'b0; o.lat = -1; o.n_pdr = 0; o.pdr_val = 1'b0;
        o.n_port = 0; o.port_val = '0; o.n_rd = 0; o.timeout = 1'b1;
        o.excl_bad = 1'b0; o.rd_at_ack = 1'b0; o.ack_after = 1'b0;
        @(negedge clk);
        bus_req = 1'b1; bus_we = we; bus_addr = addr; bus_wdata = wdata;
        @(posedge clk); #1;
        bus_we = ~we; bus_addr = addr ^ 8'h5A; bus_wdata = ~wdata;
        if (early_drop) bus_req = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (pdr_en)  begin o.n_pdr++;  o.pdr_val  = pdr_data;  end
            if (port_en) begin o.n_port++; o.port_val = port_data; end
            if (port_rd) o.n_rd++;
            if (int'(pdr_en) + int'(port_en) + int'(port_rd) > 1) o.excl_bad = 1'b1;
            if (bus_ack) begin
                o.lat = k; o.timeout = 1'b0;
                o.rdata = bus_rdata; o.err = bus_err; o.rd_at_ack = port_rd;
                break;
            end
            @(posedge clk); #1;
        end
        bus_req = 1'b0;
        @(posedge clk); #1;
        o.ack_after = bus_ack;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus_req = 1'b0; bus_we = 1'b0; bus_addr = '0;
        bus_wdata = '0; port_read_data = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus_rdata, bus_ack, bus_err, pdr_en, pdr_data, port_en, port_data, port_rd} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got rdata=%h ack=%b err=%b pdr=%b/%b port=%b/%h rd=%b required all 0",
                     bus_rdata, bus_ack, bus_err, pdr_en, pdr_data, port_en, port_data, port_rd);
        end
`ifdef IO_PORT_CHANGE_IRQ_EN
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL reset_irq got %b required 0", irq);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        m_rdata = '0; m_data = '0; m_dir = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({bus_ack, pdr_en, port_en, port_rd} !== 4'b0) begin
                errors++;
                $display("FAIL idle_quiet cycle %0d got ack/pdr/port/rd=%b required 0000",
                         i, {bus_ack, pdr_en, port_en, port_rd});
            end
        end
    endtask

    task automatic test_register_map();
        stim_t st[$];
        exp_t  e;
        obs_t  o;
        st.push_back('{1'b1, 8'hF0, 8'h01});
        st.push_back('{1'b1, 8'hF1, 8'hAA});
        st.push_back('{1'b0, 8'hF0, 8'h00});
        st.push_back('{1'b0, 8'hF1, 8'h00});
        st.push_back('{1'b0, 8'h10, 8'h00});
        st.push_back('{1'b1, 8'h10, 8'h55});
        st.push_back('{1'b1, 8'hF1, 8'h3C});
        st.push_back('{1'b1, 8'hF0, 8'hFE});
        st.push_back('{1'b0, 8'hF0, 8'h00});
        st.push_back('{1'b0, 8'hF1, 8'h00});
        st.push_back('{1'b0, 8'hEF, 8'h00});
        st.push_back('{1'b0, 8'hF4, 8'h00});
`ifndef IO_PORT_CHANGE_IRQ_EN
        st.push_back('{1'b0, 8'hF3, 8'h00});
        st.push_back('{1'b1, 8'hF3, 8'h01});
`endif
        foreach (st[i]) begin
            e = '{m_rdata, 1'b0, 1, 0, 1'b0, 0, '0, 0};
            if (st[i].addr[7:2] != 6'b111100 || st[i].addr[1:0] == 2'd3) begin
                e.err = 1'b1;
            end else if (st[i].we) begin
                e.lat = 2;
                if (st[i].addr[1:0] == 2'd0) begin
                    e.n_pdr = 1; e.pdr_val = st[i].wdata[0]; m_dir = st[i].wdata[0];
                end else begin
                    e.n_port = 1; e.port_val = st[i].wdata; m_data = st[i].wdata;
                end
            end else begin
                m_rdata = (st[i].addr[1:0] == 2'd0) ? {{(DW-1){1'b0}}, m_dir} : m_data;
                e.rdata = m_rdata;
            end
            exp_q.push_back(e);
            bus_txn(st[i].we, st[i].addr, st[i].wdata, 1'b0, o);
            e = exp_q.pop_front();
            checks++;
            if (o.timeout || o.lat != e.lat) begin
                errors++;
                $display("FAIL map_latency[%0d] addr=%h got %0d (timeout=%b) required %0d",
                         i, st[i].addr, o.lat, o.timeout, e.lat);
            end
            checks++;
            if (o.rdata !== e.rdata || o.err !== e.err) begin
                errors++;
                $display("FAIL map_resp[%0d] addr=%h got rdata=%h err=%b required rdata=%h err=%b",
                         i, st[i].addr, o.rdata, o.err, e.rdata, e.err);
            end
            checks++;
            if (o.n_pdr != e.n_pdr || o.pdr_val !== e.pdr_val || o.n_port != e.n_port ||
                o.port_val !== e.port_val || o.n_rd != e.n_rd) begin
                errors++;
                $display("FAIL map_strobes[%0d] addr=%h got pdr=%0dx%b port=%0dx%h rd=%0d required pdr=%0dx%b port=%0dx%h rd=%0d",
                         i, st[i].addr, o.n_pdr, o.pdr_val, o.n_port, o.port_val, o.n_rd,
                         e.n_pdr, e.pdr_val, e.n_port, e.port_val, e.n_rd);
            end
            checks++;
            if (o.ack_after !== 1'b0 || o.excl_bad) begin
                errors++;
                $display("FAIL map_handshake[%0d] got ack_after_req_low=%b excl_violation=%b required 0/0",
                         i, o.ack_after, o.excl_bad);
            end
        end
    endtask

    task automatic test_pin_read();
        exp_t e;
        obs_t o;
        port_read_data = 8'h5C;
        exp_q.push_back('{8'h5C, 1'b0, RW + 1, 0, 1'b0, 0, '0, RW + 1});
        bus_txn(1'b0, 8'hF2, 8'h00, 1'b0, o);
        e = exp_q.pop_front();
        m_rdata = 8'h5C;
        checks++;
        if (o.timeout || o.lat != e.lat || o.rdata !== e.rdata || o.err !== e.err) begin
            errors++;
            $display("FAIL pin_read got lat=%0d rdata=%h err=%b required lat=%0d rdata=%h err=%b",
                     o.lat, o.rdata, o.err, e.lat, e.rdata, e.err);
        end
        checks++;
        if (o.n_rd != e.n_rd || o.rd_at_ack !== 1'b0 || o.n_pdr != 0 || o.n_port != 0) begin
            errors++;
            $display("FAIL pin_window got rd_cycles=%0d rd_at_ack=%b pdr=%0d port=%0d required %0d/0/0/0",
                     o.n_rd, o.rd_at_ack, o.n_pdr, o.n_port, e.n_rd);
        end
        // BUS_RDATA must keep the pin value across an unmapped access.
        port_read_data = 8'hFF;
        exp_q.push_back('{8'h5C, 1'b1, 1, 0, 1'b0, 0, '0, 0});
        bus_txn(1'b0, 8'h10, 8'h00, 1'b0, o);
        e = exp_q.pop_front();
        checks++;
        if (o.timeout || o.lat != e.lat || o.rdata !== e.rdata || o.err !== e.err || o.n_rd != 0) begin
            errors++;
            $display("FAIL rdata_hold got lat=%0d rdata=%h err=%b rd=%0d required lat=%0d rdata=%h err=%b rd=0",
                     o.lat, o.rdata, o.err, o.n_rd, e.lat, e.rdata, e.err);
        end
    endtask

    task automatic test_req_drop();
        exp_t e;
        obs_t o;
        exp_q.push_back('{m_rdata, 1'b0, 2, 0, 1'b0, 1, 8'h33, 0});
        bus_txn(1'b1, 8'hF1, 8'h33, 1'b1, o);
        e = exp_q.pop_front();
        m_data = 8'h33;
        checks++;
        if (o.timeout || o.lat != e.lat || o.n_port != e.n_port || o.port_val !== e.port_val) begin
            errors++;
            $display("FAIL drop_write got lat=%0d port=%0dx%h required lat=%0d port=%0dx%h",
                     o.lat, o.n_port, o.port_val, e.lat, e.n_port, e.port_val);
        end
        checks++;
        if (o.ack_after !== 1'b0) begin
            errors++; $display("FAIL drop_ack_pulse got ack second cycle=%b required 0", o.ack_after);
        end
        m_rdata = 8'h33;
        exp_q.push_back('{8'h33, 1'b0, 1, 0, 1'b0, 0, '0, 0});
        bus_txn(1'b0, 8'hF1, 8'h00, 1'b1, o);
        e = exp_q.pop_front();
        checks++;
        if (o.timeout || o.lat != e.lat || o.rdata !== e.rdata || o.ack_after !== 1'b0) begin
            errors++;
            $display("FAIL drop_read got lat=%0d rdata=%h ack_after=%b required lat=%0d rdata=%h ack_after=0",
                     o.lat, o.rdata, o.ack_after, e.lat, e.rdata);
        end
    endtask

    task automatic test_rst_abort();
        exp_t e;
        obs_t o;
        logic [7:0] rd_addr [2];
        bit saw_ack;
        bus_txn(1'b1, 8'hF0, 8'h01, 1'b0, o);
        bus_txn(1'b1, 8'hF1, 8'hC3, 1'b0, o);
        @(negedge clk);
        bus_req = 1'b1; bus_we = 1'b0; bus_addr = 8'hF2; port_read_data = 8'h77;
        @(posedge clk); #1;
        checks++;
        if (port_rd !== 1'b1) begin
            errors++; $display("FAIL abort_window_open got port_rd=%b required 1", port_rd);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; bus_req = 1'b0;
        checks++;
        if (port_rd !== 1'b0 || bus_ack !== 1'b0 || bus_rdata !== '0) begin
            errors++;
            $display("FAIL abort_outputs got rd=%b ack=%b rdata=%h required 0/0/00",
                     port_rd, bus_ack, bus_rdata);
        end
        m_dir = 1'b0; m_data = '0; m_rdata = '0;
        saw_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (bus_ack) saw_ack = 1'b1;
        end
        checks++;
        if (saw_ack) begin
            errors++; $display("FAIL abort_no_ack got ack=1 required no ack");
        end
        rd_addr[0] = 8'hF0; rd_addr[1] = 8'hF1;
        foreach (rd_addr[i]) begin
            exp_q.push_back('{8'h00, 1'b0, 1, 0, 1'b0, 0, '0, 0});
            bus_txn(1'b0, rd_addr[i], 8'h00, 1'b0, o);
            e = exp_q.pop_front();
            checks++;
            if (o.timeout || o.rdata !== e.rdata || o.err !== e.err) begin
                errors++;
                $display("FAIL abort_shadow[%0d] got rdata=%h err=%b timeout=%b required %h/0",
                         i, o.rdata, o.err, o.timeout, e.rdata);
            end
        end
    endtask

`ifdef IO_PORT_CHANGE_IRQ_EN
    task automatic test_irq();
        exp_t e;
        obs_t o;
        logic          t_we  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [7:0]    t_ad  [4] = '{8'hF2, 8'hF2, 8'hF3, 8'hF2};
        logic [DW-1:0] t_pin [4] = '{8'h00, 8'h01, 8'h01, 8'h01};
        logic          t_irq [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            port_read_data = t_pin[i];
            if (t_we[i]) begin
                e = '{m_rdata, 1'b0, 2, 0, 1'b0, 0, '0, 0};
            end else begin
                m_rdata = t_pin[i];
                e = '{t_pin[i], 1'b0, RW + 1, 0, 1'b0, 0, '0, RW + 1};
            end
            exp_q.push_back(e);
            bus_txn(t_we[i], t_ad[i], 8'h01, 1'b0, o);
            e = exp_q.pop_front();
            checks++;
            if (o.timeout || o.lat != e.lat || o.rdata !== e.rdata || o.err !== e.err || o.n_rd != e.n_rd) begin
                errors++;
                $display("FAIL irq_txn[%0d] got lat=%0d rdata=%h err=%b rd=%0d required lat=%0d rdata=%h err=%b rd=%0d",
                         i, o.lat, o.rdata, o.err, o.n_rd, e.lat, e.rdata, e.err, e.n_rd);
            end
            checks++;
            if (irq !== t_irq[i]) begin
                errors++; $display("FAIL irq_flag[%0d] got %b required %b", i, irq, t_irq[i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_register_map();
        test_pin_read();
        test_req_drop();
        test_rst_abort();
`ifdef IO_PORT_CHANGE_IRQ_EN
        test_irq();
`endif
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain got %0d entries required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/io_port_bus_ctrl.md
Name: io_port_bus_ctrl

Overview:
- Bus-side controller for the GPIO port block: port direction register, port data register, and the two tri-state buffers.
- Accepts four-phase request/acknowledge transactions from the CPU side and decodes a small register window.
- Generates the single-cycle PDR_EN / PORT_EN write strobes and the PORT_RD read window.
- Captures PORT_READ_DATA back onto the CPU bus.

Parameters:
- DATA_W, 8: width of port data, BUS_WDATA, BUS_RDATA, PORT_DATA and PORT_READ_DATA.
- BASE_ADDR, 8'hF0: base of the 4-entry register window. Must be 4-aligned.
- READ_WAIT, 1: cycles PORT_RD is held before capture. Legal range 0..7.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- RST  input  1  synchronous, active-high reset.
- BUS_REQ  input  1  transaction request, held high until BUS_ACK is seen.
- BUS_WE  input  1  1 = write, 0 = read; sampled with BUS_REQ.
- BUS_ADDR  input  8  register address; sampled with BUS_REQ.
- BUS_WDATA  input  DATA_W  write data; sampled with BUS_REQ.
- BUS_RDATA  output  DATA_W  read data; valid while BUS_ACK=1 for reads.
- BUS_ACK  output  1  acknowledge.
- BUS_ERR  output  1  unmapped address; valid while BUS_ACK=1.
- PDR_EN  output  1  direction register load strobe.
- PDR_DATA  output  1  direction bit to load (1 = drive pins).
- PORT_EN  output  1  data register load strobe.
- PORT_DATA  output  DATA_W  value to load into the port data register.
- PORT_RD  output  1  read-path enable; pins are released while high.
- PORT_READ_DATA  input  DATA_W  data from the read tri-state buffer.

Behaviour:
- Register map:
  - BASE+0: DIR, R/W, bit0 only; reads return {0..., dir_shadow}.
  - BASE+1: DATA, R/W; reads return data_shadow.
  - BASE+2: PIN, RO; reads go through the PORT_RD window. Writes are acked with no effect.
  - BASE+3: IRQ clear (optional feature only; otherwise unmapped).
  - Any other address: acked with BUS_ERR=1, no strobes, BUS_RDATA unchanged.
- All outputs are registered.
- Reset values:
  - State IDLE; all strobes, PORT_RD, BUS_ACK and BUS_ERR are 0.
  - BUS_RDATA, PORT_DATA, PDR_DATA, dir_shadow and data_shadow are 0.
- FSM states: IDLE, WRITE, RD_WAIT, ACK.
- IDLE:
  - On the edge where BUS_REQ=1, latch WE, ADDR and WDATA.
  - Mapped write -> WRITE. PIN read -> RD_WAIT. All other cases -> ACK.
- WRITE:
  - PDR_EN (DIR) or PORT_EN (DATA) is high for exactly one cycle, with PDR_DATA/PORT_DATA already stable that cycle. The shadow register updates on the same edge.
  - Next state is ACK.
- RD_WAIT:
  - PORT_RD goes high in the cycle after the request edge and stays high for READ_WAIT+1 cycles.
  - On the final edge, BUS_RDATA <= PORT_READ_DATA, PORT_RD <= 0, BUS_ACK <= 1, then ACK.
  - READ_WAIT=0 gives a one-cycle PORT_RD pulse.
- Shadow reads (DIR/DATA): BUS_RDATA loads on the request edge; ACK follows.
- ACK:
  - BUS_ACK is high until BUS_REQ is sampled low; BUS_ACK clears on that edge and the FSM returns to IDLE.
  - A new request needs BUS_REQ low for at least one edge.
- Latency from the request edge to BUS_ACK high:
  - Write: 2 cycles.
  - Shadow read or unmapped: 1 cycle.
  - PIN read: READ_WAIT+1 cycles.
- PDR_EN, PORT_EN and PORT_RD are mutually exclusive; never more than one is high.
- BUS_RDATA holds its last captured value between reads.
- RST mid-transaction: the FSM goes to IDLE on that edge. Strobes, PORT_RD and BUS_ACK drop; no ack is issued for the aborted request; shadows return to reset values.
- BUS_REQ dropped before ack: the transaction still completes. BUS_ACK pulses for one cycle, then the FSM returns to IDLE.
- BUS_ADDR, BUS_WE and BUS_WDATA changes after the request edge are ignored.

Optional Feature:
- Macro IO_PORT_CHANGE_IRQ_EN.
- When defined:
  - Adds output IRQ (1 bit) and an internal DATA_W last_pin register; both reset to 0.
  - On each PIN capture, if PORT_READ_DATA != last_pin, IRQ <= 1 (sticky); last_pin <= PORT_READ_DATA.
  - A write to BASE+3 clears IRQ in the WRITE cycle. If a clear and a set land on the same edge, set wins.
- When undefined: no IRQ port, and BASE+3 is unmapped (BUS_ERR).

Test Plan:
- Reset, then idle -> all outputs 0 and BUS_ACK stays 0 with BUS_REQ=0 for 10 cycles.
- Write 8'h01 to F0, then 8'hAA to F1 -> PDR_EN one cycle with PDR_DATA=1, then PORT_EN one cycle with PORT_DATA=8'hAA. BUS_ACK 2 cycles after each request; reads of F0/F1 return 8'h01/8'hAA.
- PIN read with READ_WAIT=1, PORT_READ_DATA=8'h5C -> PORT_RD high exactly 2 cycles, BUS_RDATA=8'h5C with BUS_ACK, PORT_RD low during ACK.
- Read at address 8'h10 -> BUS_ACK and BUS_ERR high 1 cycle after the request, no strobes, BUS_RDATA unchanged.
- Assert RST during RD_WAIT -> PORT_RD=0 on the next edge, no BUS_ACK, shadows read back 0 afterwards.
- With IO_PORT_CHANGE_IRQ_EN: PIN reads returning 8'h00 then 8'h01 -> IRQ=1 after the second read; write to F3 -> IRQ=0; a third read of 8'h01 leaves IRQ=0.
